// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state type and default geometry for the parametrised RAM.
package ram_pkg;
  typedef enum logic {INIT, IDLE} ram_state_t;
  localparam int RAM_WIDTH_DEF = 16;
  localparam int RAM_DEPTH_DEF = 8;
endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset zero-fill sweep; raises ready once every entry has been cleared.
module ram_init_seq import ram_pkg::*; #(
  parameter int DEPTH = RAM_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          ready,
  output logic          init_we,
  output logic [AW-1:0] init_addr
);
  ram_state_t state;
  logic [AW-1:0] cnt;
  assign init_addr = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      cnt     <= '0;
      ready   <= 1'b0;
      init_we <= 1'b1;
    end else if (state == INIT) begin
      cnt <= cnt + AW'(1);
      // the edge that clears the last entry is also the one that opens the port
      if (cnt == AW'(DEPTH - 1)) begin
        state   <= IDLE;
        ready   <= 1'b1;
        init_we <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ram_param.sv
// ram_param: WIDTH x DEPTH RAM with registered read port, read strobe/valid and zero-fill after reset.
// Define RAM_WRITE_FIRST_EN to forward write data on a same-address load+rd; otherwise reads are read-first.
module ram_param import ram_pkg::*; #(
  parameter int WIDTH = RAM_WIDTH_DEF,
  parameter int DEPTH = RAM_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             rd,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             ready
);
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rdata;

  ram_init_seq #(.DEPTH(DEPTH)) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  always_comb begin
    we = ready ? load : init_we;
    wa = ready ? address : init_addr;
    wd = ready ? in : '0;
  end

`ifdef RAM_WRITE_FIRST_EN
  assign rdata = load ? ((address == wa) ? in : mem[address]) : mem[address];
`else
  assign rdata = mem[address];
`endif

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= ready & rd;
      if (ready && rd) out <= rdata;
    end
  end
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: randomized and directed checks of ram_param against an array-based reference model.
module tb_ram_param;
  import ram_pkg::*;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef RAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        rd = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic        valid;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] m_mem [0:DEPTH-1];
  logic [15:0] m_out;
  logic        m_valid;
  int          e;

  ram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .rd(rd),
    .address(address), .in(in), .out(out), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"}, {15'b0, ready}, {15'b0, e >= DEPTH});
    check({tag, ".valid"}, {15'b0, valid}, {15'b0, m_valid});
    check({tag, ".out"}, out, m_out);
  endtask

  // one clock: commands are accepted only once DEPTH sweep edges have passed since release
  task automatic cyc(input logic l, input logic r, input logic [2:0] a, input logic [15:0] d, input string tag);
    load = l; rd = r; address = a; in = d;
    @(posedge clk);
    if (e >= DEPTH) begin
      m_valid = r;
      if (r) m_out = (l && WF) ? d : m_mem[a];
      if (l) m_mem[a] = d;
    end else begin
      m_mem[e] = '0;
      m_valid = 1'b0;
    end
    e++;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; rd = 1'b0;
    #1;
    m_out = '0; m_valid = 1'b0; e = 0;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h5a5a;
    #2;
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc(k == 3, k[0], 3'd2, 16'hFFFF, "init");
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 3'(k), 16'h0, "zero_rd");
    cyc(1'b1, 1'b0, 3'd3, 16'hBEEF, "wr3");
    cyc(1'b1, 1'b0, 3'd7, 16'h1234, "wr7");
    cyc(1'b0, 1'b1, 3'd3, 16'h0, "rd3");
    check("rd3_const", out, 16'hBEEF);
    cyc(1'b0, 1'b1, 3'd7, 16'h0, "rd7");
    check("rd7_const", out, 16'h1234);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 3'(k), 16'hdead, "hold");
    check("hold_const", out, 16'h1234);
    cyc(1'b1, 1'b0, 3'd5, 16'h00AA, "wr5");
    cyc(1'b1, 1'b1, 3'd5, 16'h5555, "wr_rd5");
    check("wr_rd5_const", out, WF ? 16'h5555 : 16'h00AA);
    cyc(1'b0, 1'b1, 3'd5, 16'h0, "rd5_after");
    check("rd5_after_const", out, 16'h5555);
    cyc(1'b1, 1'b1, 3'd0, 16'h0F0F, "diff_a");
    cyc(1'b1, 1'b1, 3'd6, 16'hA0A0, "diff_b");
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom), "rand");
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 3'(k), 16'h0, "scan");
    cyc(1'b1, 1'b0, 3'd1, 16'hCAFE, "wr1");
    cyc(1'b0, 1'b1, 3'd1, 16'h0, "rd1");
    check("rd1_const", out, 16'hCAFE);
    #2;
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 3'd1, 16'h0, "reinit");
    cyc(1'b0, 1'b1, 3'd1, 16'h0, "rd1_zero");
    check("rd1_zero_const", out, 16'h0000);
    for (int k = 0; k < 200; k++)
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom), "rand2");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
